// File: rtl/hwint_ctrl_pkg.sv
// Shared constants and helpers for the hardware interrupt controller.
package hwint_ctrl_pkg;

    localparam int unsigned NumSrc      = 6;
    localparam logic [31:0] BaseDefault = 32'h0000_7F40;

    // Word offsets within the 16-byte register window (addr[3:2]).
    typedef enum logic [1:0] {
        RegEnable  = 2'd0,
        RegMode    = 2'd1,
        RegPending = 2'd2,
        RegRaw     = 2'd3
    } reg_off_e;

    // One-hot mask of the lowest set bit of v; zero when v is zero.
    function automatic logic [NumSrc-1:0] lowest_set(input logic [NumSrc-1:0] v);
        logic [NumSrc-1:0] r;
        logic              found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NumSrc); i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/int_sync.sv
// Two-flop synchroniser bank for asynchronous level inputs.
module int_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    // Shift raw inputs through two flops to settle metastability.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule

// File: rtl/hwint_ctrl.sv
// Memory-mapped interrupt controller: synchronises device lines, captures
// level or edge events into PENDING and presents pending & ENABLE to CP0.
module hwint_ctrl
    import hwint_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE = BaseDefault
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NumSrc-1:0] src,
    input  logic [31:0]       addr,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic              ack,
    output logic [NumSrc-1:0] hwint
);

    logic [NumSrc-1:0] r_enable;
    logic [NumSrc-1:0] r_mode;
    logic [NumSrc-1:0] r_pending;
    logic [NumSrc-1:0] r_prev;

    logic [NumSrc-1:0] w_s2;
    logic              w_hit;
    reg_off_e          w_off;
    logic              w_wr;
    logic              w_mode_wr;
    logic [NumSrc-1:0] w_rise;
    logic [NumSrc-1:0] w_w1c;
    logic [NumSrc-1:0] w_ack_clr;
    logic [NumSrc-1:0] w_clr;
    logic [NumSrc-1:0] w_pending_nxt;
    logic              w_unused;

    int_sync #(
        .WIDTH (NumSrc)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (src),
        .q     (w_s2)
    );

    assign w_hit     = (addr[31:4] == BASE[31:4]);
    assign w_off     = reg_off_e'(addr[3:2]);
    assign w_wr      = w_hit & we;
    assign w_mode_wr = w_wr && (w_off == RegMode);

    assign hwint     = r_pending & r_enable;
    assign w_rise    = w_s2 & ~r_prev;
    assign w_w1c     = (w_wr && (w_off == RegPending)) ? wdata[NumSrc-1:0] : '0;
    // ack only retires edge-mode sources; level sources clear themselves.
    assign w_ack_clr = ack ? lowest_set(hwint & r_mode) : '0;
    assign w_clr     = w_w1c | w_ack_clr;

    assign w_unused  = ^{addr[1:0], wdata[31:NumSrc]};

    // Per-bit pending capture; a new edge beats a same-cycle clear.
    always_comb begin
        w_pending_nxt = '0;
        for (int i = 0; i < int'(NumSrc); i++) begin
            if (w_mode_wr && wdata[i] && !r_mode[i]) begin
                // Switching level->edge discards the stale level value.
                w_pending_nxt[i] = 1'b0;
            end else if (r_mode[i]) begin
                w_pending_nxt[i] = (r_pending[i] & ~w_clr[i]) | w_rise[i];
            end else begin
                w_pending_nxt[i] = w_s2[i];
            end
        end
    end

    // Register file and edge-detect history.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable  <= '0;
            r_mode    <= '0;
            r_pending <= '0;
            r_prev    <= '0;
        end else begin
            r_prev    <= w_s2;
            r_pending <= w_pending_nxt;
            if (w_wr && (w_off == RegEnable)) begin
                r_enable <= wdata[NumSrc-1:0];
            end
            if (w_mode_wr) begin
                r_mode <= wdata[NumSrc-1:0];
            end
        end
    end

    // Combinational read mux; zero outside the window.
    always_comb begin
        rdata = '0;
        if (w_hit) begin
            unique case (w_off)
                RegEnable:  rdata = {{(32-NumSrc){1'b0}}, r_enable};
                RegMode:    rdata = {{(32-NumSrc){1'b0}}, r_mode};
                RegPending: rdata = {{(32-NumSrc){1'b0}}, r_pending};
                RegRaw:     rdata = {{(32-NumSrc){1'b0}}, w_s2};
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_hwint_ctrl.sv
// Directed self-checking bench for hwint_ctrl.
module tb_hwint_ctrl;

    localparam logic [31:0] Base   = 32'h0000_7F40;
    localparam logic [31:0] AEn    = Base + 32'h0;
    localparam logic [31:0] AMode  = Base + 32'h4;
    localparam logic [31:0] APend  = Base + 32'h8;
    localparam logic [31:0] ARaw   = Base + 32'hC;

    logic        clk;
    logic        reset;
    logic [5:0]  src;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic [5:0]  hwint;

    int checks;
    int errors;

    hwint_ctrl #(
        .BASE (Base)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .src   (src),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .hwint (hwint)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic a_ack);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        ack   = a_ack;
        step();
        we    = 1'b0;
        ack   = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d    = rdata;
        addr = 32'h0;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        check_eq(tag, v, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        src    = '0;
        addr   = '0;
        we     = 1'b0;
        wdata  = '0;
        ack    = 1'b0;
        step_n(2);
        reset  = 1'b0;

        // Reset state
        check_eq("rst_hwint", {26'b0, hwint}, 32'h0);
        check_reg("rst_enable", AEn, 32'h0);
        check_reg("rst_mode", AMode, 32'h0);
        check_reg("rst_pending", APend, 32'h0);
        check_reg("rst_raw", ARaw, 32'h0);

        // Level mode latency on rise and fall
        bus_write(AEn, 32'h04, 1'b0);
        bus_write(AMode, 32'h00, 1'b0);
        src = 6'h04;
        step_n(2);
        check_eq("lvl_rise_k1", {26'b0, hwint}, 32'h0);
        step();
        check_eq("lvl_rise_k2", {26'b0, hwint}, 32'h04);
        src = 6'h00;
        step_n(2);
        check_eq("lvl_fall_k1", {26'b0, hwint}, 32'h04);
        step();
        check_eq("lvl_fall_k2", {26'b0, hwint}, 32'h0);

        // Edge capture and ack priority
        bus_write(AEn, 32'h3F, 1'b0);
        bus_write(AMode, 32'h3F, 1'b0);
        src = 6'h0A;
        step_n(3);
        src = 6'h00;
        step_n(3);
        check_reg("edge_pending", APend, 32'h0A);
        check_eq("edge_hwint", {26'b0, hwint}, 32'h0A);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_reg("ack1_pending", APend, 32'h08);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_reg("ack2_pending", APend, 32'h00);

        // W1C colliding with a new edge: set wins
        src = 6'h01;
        step_n(3);
        src = 6'h00;
        step_n(3);
        check_reg("coll_pre", APend, 32'h01);
        src = 6'h01;
        step_n(2);
        bus_write(APend, 32'h01, 1'b0);
        check_reg("coll_set_wins", APend, 32'h01);
        bus_write(APend, 32'h01, 1'b0);
        check_reg("w1c_clear", APend, 32'h00);
        src = 6'h00;
        step_n(3);

        // W1C and ack in the same cycle clear the union
        src = 6'h15;
        step_n(3);
        src = 6'h00;
        step_n(3);
        check_reg("union_pre", APend, 32'h15);
        bus_write(APend, 32'h10, 1'b1);
        check_reg("union_post", APend, 32'h04);

        // Enable masks hwint but not capture
        bus_write(AEn, 32'h00, 1'b0);
        bus_write(APend, 32'h3F, 1'b0);
        src = 6'h20;
        step_n(3);
        src = 6'h00;
        step_n(3);
        check_eq("mask_hwint", {26'b0, hwint}, 32'h0);
        check_reg("mask_pending", APend, 32'h20);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_reg("ack_noop", APend, 32'h20);
        bus_write(AEn, 32'h20, 1'b0);
        check_eq("unmask_hwint", {26'b0, hwint}, 32'h20);

        // Mode switches
        bus_write(AMode, 32'h00, 1'b0);
        src = 6'h02;
        step_n(3);
        check_reg("lvl_follow", APend, 32'h02);
        bus_write(AMode, 32'h02, 1'b0);
        check_reg("to_edge_clr", APend, 32'h00);
        step_n(2);
        check_reg("to_edge_hold", APend, 32'h00);
        bus_write(AMode, 32'h00, 1'b0);
        check_reg("to_lvl_edge0", APend, 32'h00);
        step();
        check_reg("to_lvl_edge1", APend, 32'h02);
        src = 6'h00;
        step_n(3);

        // Reset mid-operation overrides a simultaneous write and ack
        src = 6'h3F;
        step_n(3);
        check_reg("pre_rst_pend", APend, 32'h3F);
        reset = 1'b1;
        addr  = AEn;
        wdata = 32'h3F;
        we    = 1'b1;
        ack   = 1'b1;
        step();
        reset = 1'b0;
        we    = 1'b0;
        ack   = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        check_eq("mid_rst_hwint", {26'b0, hwint}, 32'h0);
        check_reg("mid_rst_en", AEn, 32'h0);
        check_reg("mid_rst_mode", AMode, 32'h0);
        check_reg("mid_rst_pend", APend, 32'h0);
        check_reg("mid_rst_raw", ARaw, 32'h0);
        step();
        check_reg("raw_rel1", ARaw, 32'h0);
        step();
        check_reg("raw_rel2", ARaw, 32'h3F);
        src = 6'h00;
        step_n(3);

        // Address decode
        bus_write(AEn, 32'h05, 1'b0);
        bus_write(Base + 32'h10, 32'h3F, 1'b0);
        bus_write(Base - 32'h4, 32'h3F, 1'b0);
        check_reg("dec_en_kept", AEn, 32'h05);
        check_reg("dec_mode_kept", AMode, 32'h00);
        check_reg("dec_rd_hi", Base + 32'h10, 32'h0);
        check_reg("dec_rd_lo", Base - 32'h4, 32'h0);
        check_reg("dec_byte_lanes", Base + 32'h1, 32'h05);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hwint_ctrl.md
HWINT_CTRL -- requirements
Module: hwint_ctrl

Interface
REQ-001 Parameter: BASE, 32'h0000_7F40, word-aligned base of the 16-byte register window.
REQ-002 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: src  in  6  raw device interrupt lines, unsynchronised.
REQ-005 Port: addr  in  32  bus byte address; bits [1:0] ignored.
REQ-006 Port: we  in  1  bus write enable.
REQ-007 Port: wdata  in  32  bus write data.
REQ-008 Port: rdata  out  32  combinational read data for addr.
REQ-009 Port: ack  in  1  one-cycle pulse from the exception unit: the current interrupt has been taken.
REQ-010 Port: hwint  out  6  pending & enable, drives the CP0 HWInt input.

Function
REQ-011 The block SHALL hit when addr[31:4]==BASE[31:4]; offset = addr[3:2].
REQ-012 The registers SHALL be: 0 ENABLE[5:0] rw; 1 MODE[5:0] rw (1=edge, 0=level); 2 PENDING[5:0] r, write-1-to-clear; 3 RAW[5:0] r (synchronised src).
REQ-013 rdata SHALL be {26'b0, reg[5:0]} on a hit, else 32'b0; writes without a hit SHALL be ignored.
REQ-014 Each src bit SHALL pass a 2-flop synchroniser (s1, s2), plus a prev register holding the previous s2.
REQ-015 Level bit: pending[i] SHALL load s2[i] every cycle; W1C and ack SHALL have no effect on it.
REQ-016 Edge bit: pending[i] SHALL set when s2[i]&~prev[i], and hold until cleared by a W1C write or an ack.
REQ-017 Latency: src[i] first sampled high at edge k -> pending[i] and hwint[i] high after edge k+2, in both modes.
REQ-018 A set and a clear of the same edge bit in one cycle SHALL leave the bit set.
REQ-019 ack SHALL clear only the lowest-numbered bit i with hwint[i]=1 and MODE[i]=1; ack with hwint==0 SHALL be a no-op.
REQ-020 hwint SHALL equal pending & ENABLE combinationally; ENABLE SHALL NOT gate pending capture.
REQ-021 A MODE write edge->level SHALL make pending follow s2 from the next edge.
REQ-022 A MODE write level->edge SHALL clear that pending bit at the write edge; only a later rising edge sets it.
REQ-023 A W1C write and an ack in the same cycle SHALL both apply (union of cleared bits).
REQ-024 A src pulse shorter than one clock MAY be lost; this is a documented limitation, not an error.

Reset
REQ-025 On reset high at a rising edge: ENABLE, MODE, PENDING, s1, s2 and prev SHALL become 0, so hwint=0 after the edge.
REQ-026 Reset SHALL override any simultaneous write, ack or src edge.
REQ-027 A src held high through reset release SHALL NOT produce an edge-mode pending bit, since MODE=0 after reset.

Structure
REQ-028 Register offsets (ENABLE, MODE, PENDING, RAW) and the BASE default SHALL live in the shared constants header.
REQ-029 The synchroniser SHALL be a sub-module int_sync (parameter WIDTH, ports clk, reset, d, q), instanced once with WIDTH=6.
REQ-030 The RTL SHALL stay within 120-400 lines.

Verification
REQ-031 Level: write ENABLE=6'h04, MODE=0; raise src[2] at edge k -> hwint=6'h04 after edge k+2; drop src[2] -> hwint=0 two edges later.
REQ-032 Edge and ack: ENABLE=6'h3F, MODE=6'h3F; pulse src[3] and src[1] for 3 cycles -> PENDING=6'h0A; ack -> PENDING=6'h08; ack -> 6'h00.
REQ-033 W1C/set collision: MODE[0]=1, pending[0]=1; write PENDING=6'h01 in the cycle a new src[0] edge reaches s2 -> PENDING[0] stays 1.
REQ-034 Enable masking: edge bit 5 pending with ENABLE=0 -> hwint=0 and PENDING read=32'h20; write ENABLE=6'h20 -> hwint=6'h20 the same cycle.
REQ-035 Reset mid-operation: PENDING=6'h3F and src held high; assert reset one cycle -> all registers and hwint read 0; rdata of RAW returns 6'h3F two edges after release.
REQ-036 Decode: write to BASE+32'h10 or BASE-4 -> no register changes; read -> rdata=0.
